// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill controllers.
// Block geometry: 16-byte blocks of eight 16-bit words.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int BLOCK_BYTES     = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_OFFSET_W   = 3;
    localparam int CNT_W           = 4;

    // Clears the byte offset within a block; sliced down to the address width by users.
    localparam logic [31:0] BLOCK_BASE_MASK = ~32'(BLOCK_BYTES - 1);

endpackage

// File: rtl/fill_counter.sv
// 4-bit word counter used to track issued requests and received words of a fill.
// Synchronous clear has priority over enable.
module fill_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: stalls the pipeline, streams eight word reads, writes data then tag.
// Optional CACHE_FILL_CRITICAL_WORD_FIRST_EN starts the fill at the missed word and wraps.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              memory_read_en,
    output logic [ADDR_W-1:0] memory_address,
    input  logic [15:0]       memory_data,
    input  logic              memory_data_valid,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] data_word_address,
    output logic              write_tag_array
);

    import cache_pkg::*;

    localparam logic [CNT_W-1:0]  BLOCK_WORDS = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK   = BLOCK_BASE_MASK[ADDR_W-1:0];

    fill_state_t              state, state_next;
    logic [ADDR_W-1:0]        base;
    logic                     start_fill;
    logic [CNT_W-1:0]         issue_cnt, recv_cnt;
    logic [WORD_OFFSET_W-1:0] issue_word, recv_word;

    // The data path goes straight from memory to the array; only the valid strobe matters here.
    logic unused_memory_data;
    assign unused_memory_data = ^memory_data;

    assign start_fill = (state == IDLE) && miss_detected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            state <= state_next;
            if (start_fill) begin
                base <= miss_address & BASE_MASK;
            end
        end
    end

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [WORD_OFFSET_W-1:0] miss_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_word <= '0;
        end else if (start_fill) begin
            miss_word <= miss_address[WORD_OFFSET_W:1];
        end
    end

    // Word index wraps in its own width, so offsets never carry into the block base.
    assign issue_word = miss_word + issue_cnt[WORD_OFFSET_W-1:0];
    assign recv_word  = miss_word + recv_cnt[WORD_OFFSET_W-1:0];
`else
    assign issue_word = issue_cnt[WORD_OFFSET_W-1:0];
    assign recv_word  = recv_cnt[WORD_OFFSET_W-1:0];
`endif

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_fill),
        .en    (memory_read_en),
        .count (issue_cnt)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_fill),
        .en    (write_data_array),
        .count (recv_cnt)
    );

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next        = state;
        fsm_busy          = 1'b0;
        memory_read_en    = 1'b0;
        memory_address    = '0;
        write_data_array  = 1'b0;
        data_word_address = '0;
        write_tag_array   = 1'b0;

        case (state)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt < BLOCK_WORDS) begin
                    memory_read_en = 1'b1;
                    memory_address = base | ADDR_W'({issue_word, 1'b0});
                end
                // Issue and receive are independent, so early data may overlap requests.
                if (memory_data_valid) begin
                    write_data_array  = 1'b1;
                    data_word_address = base | ADDR_W'({recv_word, 1'b0});
                    if (recv_cnt == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: queue-based reference model, directed scenarios and random fills.
// The expected word order follows CACHE_FILL_CRITICAL_WORD_FIRST_EN when it is defined.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0000;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic [15:0] memory_data = 16'h0000;
    logic        memory_data_valid = 1'b0;
    logic        write_data_array;
    logic [15:0] data_word_address;
    logic        write_tag_array;

    cache_fill_fsm #(
        .WORDS_PER_BLOCK (8),
        .ADDR_W          (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .write_data_array  (write_data_array),
        .data_word_address (data_word_address),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 4;
    int c0 = 0;
    bit spurious = 1'b0;
    bit sched [64];

    // Reference model: pending request and write addresses of the fill in progress.
    bit          m_active = 1'b0;
    logic [15:0] req_q [$];
    logic [15:0] wr_q  [$];

    // Observed DUT activity for the directed scenarios.
    logic [15:0] req_log [$];
    logic [15:0] wr_log  [$];
    int          req_cyc [$];
    int          wr_cyc  [$];
    int          tag_cyc [$];
    int          busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_start(input logic [15:0] addr);
        logic [15:0] base;
        int w;
        base = addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            w = (int'(addr[3:1]) + i) % 8;
`else
            w = i;
`endif
            req_q.push_back(base + 16'(2 * w));
            wr_q.push_back(base + 16'(2 * w));
        end
        m_active = 1'b1;
    endfunction

    function automatic logic [15:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 16'hxxxx;
    endfunction

    function automatic logic [15:0] wr_at(input int i);
        return (i < wr_log.size()) ? wr_log[i] : 16'hxxxx;
    endfunction

    function automatic int rc_at(input int i);
        return (i < req_cyc.size()) ? req_cyc[i] : -1;
    endfunction

    function automatic int wc_at(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
    endfunction

    function automatic int tag_at(input int i);
        return (i < tag_cyc.size()) ? tag_cyc[i] : -1;
    endfunction

    function automatic int count_in_block(input logic [15:0] base, input bit use_wr);
        int n = 0;
        if (use_wr) begin
            foreach (wr_log[i]) if ((wr_log[i] & 16'hFFF0) == base) n++;
        end else begin
            foreach (req_log[i]) if ((req_log[i] & 16'hFFF0) == base) n++;
        end
        return n;
    endfunction

    task automatic clear_logs();
        req_log.delete();
        wr_log.delete();
        req_cyc.delete();
        wr_cyc.delete();
        tag_cyc.delete();
        busy_cnt = 0;
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        memory_data_valid = sched[cyc % 64] | spurious;
        sched[cyc % 64] = 1'b0;
        memory_data = 16'($urandom);
    endtask

    task automatic start_miss(input logic [15:0] addr);
        miss_detected = 1'b1;
        miss_address = addr;
        c0 = cyc;
        tick();
        miss_detected = 1'b0;
        miss_address = 16'($urandom);
    endtask

    task automatic wait_idle(input bit noisy);
        int n = 0;
        while (m_active && n < 100) begin
            if (noisy) begin
                miss_detected = ($urandom_range(0, 3) == 0);
                miss_address = 16'($urandom);
            end
            tick();
            n++;
        end
        miss_detected = 1'b0;
        if (m_active) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fill_timeout: fill still active after %0d cycles, expected completion", n);
        end
    endtask

    // Compare process, memory responder and model update, all on the falling edge.
    always @(negedge clk) begin
        bit e_busy, e_rd, e_wr, e_tag;
        if (!rst_n) begin
            check("rst_fsm_busy", fsm_busy, 0);
            check("rst_memory_read_en", memory_read_en, 0);
            check("rst_write_data_array", write_data_array, 0);
            check("rst_write_tag_array", write_tag_array, 0);
            check("rst_memory_address", memory_address, 0);
            check("rst_data_word_address", data_word_address, 0);
            m_active = 1'b0;
            req_q.delete();
            wr_q.delete();
        end else begin
            e_busy = m_active || miss_detected;
            e_rd   = m_active && (req_q.size() != 0);
            e_wr   = m_active && memory_data_valid;
            e_tag  = e_wr && (wr_q.size() == 1);
            check("fsm_busy", fsm_busy, e_busy);
            check("memory_read_en", memory_read_en, e_rd);
            check("write_data_array", write_data_array, e_wr);
            check("write_tag_array", write_tag_array, e_tag);
            if (e_rd) check("memory_address", memory_address, req_q[0]);
            if (e_wr && wr_q.size() != 0) check("data_word_address", data_word_address, wr_q[0]);

            if (fsm_busy) busy_cnt++;
            if (memory_read_en) begin
                req_log.push_back(memory_address);
                req_cyc.push_back(cyc);
                sched[(cyc + lat) % 64] = 1'b1;
            end
            if (write_data_array) begin
                wr_log.push_back(data_word_address);
                wr_cyc.push_back(cyc);
            end
            if (write_tag_array) tag_cyc.push_back(cyc);

            if (e_rd) void'(req_q.pop_front());
            if (e_wr && wr_q.size() != 0) void'(wr_q.pop_front());
            if (e_tag) m_active = 1'b0;
            else if (!m_active && miss_detected) model_start(miss_address);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_a [8];
        logic [15:0] exp_ff_first, exp_ff_last;
        int gap;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        exp_a = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
        exp_ff_first = 16'hFFFE;
        exp_ff_last  = 16'hFFFC;
`else
        exp_a = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
        exp_ff_first = 16'hFFF0;
        exp_ff_last  = 16'hFFFE;
`endif

        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("reset_fsm_busy", fsm_busy, 0);
        check("reset_memory_read_en", memory_read_en, 0);
        check("reset_write_tag_array", write_tag_array, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Miss at 0x1236 with a 4-cycle memory.
        clear_logs();
        start_miss(16'h1236);
        repeat (18) tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a_req_addr%0d", i), req_at(i), exp_a[i]);
            check($sformatf("a_wr_addr%0d", i), wr_at(i), exp_a[i]);
        end
        check("a_req_count", req_log.size(), 8);
        check("a_req_first_cycle", rc_at(0), c0 + 1);
        check("a_req_last_cycle", rc_at(7), c0 + 8);
        check("a_wr_first_cycle", wc_at(0), c0 + 5);
        check("a_wr_last_cycle", wc_at(7), c0 + 12);
        check("a_tag_count", tag_cyc.size(), 1);
        check("a_tag_cycle", tag_at(0), c0 + 12);
        check("a_busy_cycles", busy_cnt, 13);

        // Top-of-memory block: offsets must not carry out of the block.
        clear_logs();
        start_miss(16'hFFFF);
        repeat (18) tick();
        check("ff_req_in_block", count_in_block(16'hFFF0, 1'b0), 8);
        check("ff_wr_in_block", count_in_block(16'hFFF0, 1'b1), 8);
        check("ff_first_addr", req_at(0), exp_ff_first);
        check("ff_last_addr", req_at(7), exp_ff_last);
        check("ff_tag_count", tag_cyc.size(), 1);

        // Misses during FILL and valids during IDLE are ignored.
        clear_logs();
        spurious = 1'b1;
        repeat (3) tick();
        spurious = 1'b0;
        start_miss(16'h2000);
        tick();
        miss_detected = 1'b1;
        miss_address = 16'h4000;
        repeat (3) tick();
        miss_detected = 1'b0;
        repeat (16) tick();
        spurious = 1'b1;
        repeat (3) tick();
        spurious = 1'b0;
        tick();
        check("ign_req_count", req_log.size(), 8);
        check("ign_req_in_block", count_in_block(16'h2000, 1'b0), 8);
        check("ign_wr_count", wr_log.size(), 8);
        check("ign_wr_in_block", count_in_block(16'h2000, 1'b1), 8);
        check("ign_tag_count", tag_cyc.size(), 1);

        // Reset during a fill; late memory returns must not write anything.
        start_miss(16'h3456);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_fsm_busy", fsm_busy, 0);
        check("midrst_memory_read_en", memory_read_en, 0);
        check("midrst_write_data_array", write_data_array, 0);
        tick();
        rst_n = 1'b1;
        clear_logs();
        repeat (15) tick();
        check("midrst_wr_after", wr_log.size(), 0);
        check("midrst_tag_after", tag_cyc.size(), 0);
        check("midrst_req_after", req_log.size(), 0);
        check("midrst_busy_after", busy_cnt, 0);

        // Back-to-back: second miss in the first IDLE cycle after the tag write.
        clear_logs();
        start_miss(16'h5A5A);
        repeat (12) tick();
        miss_detected = 1'b1;
        miss_address = 16'h6000;
        tick();
        miss_detected = 1'b0;
        repeat (18) tick();
        check("b2b_tag_count", tag_cyc.size(), 2);
        check("b2b_tag0_cycle", tag_at(0), c0 + 12);
        check("b2b_tag1_cycle", tag_at(1), c0 + 25);
        check("b2b_second_req_cycle", rc_at(8), c0 + 14);
        check("b2b_second_req_addr", req_at(8), 16'h6000);
        check("b2b_busy_cycles", busy_cnt, 26);

        // Random fills: varied latency (including data overlapping requests), gaps and noise.
        for (int f = 0; f < 40; f++) begin
            lat = $urandom_range(1, 6);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                spurious = ($urandom_range(0, 1) == 1);
                tick();
            end
            spurious = 1'b0;
            start_miss(16'($urandom));
            wait_idle(1'b1);
        end
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
